l2cache_nway: RTL and testbench

Parametrised N-way set-associative, write-back, write-allocate L2 cache for the LC-3b memory hierarchy. It sits between the L1/arbiter side (cpu port, 128-bit lines) and physical memory (mem port, 128-bit lines). It integrates its own miss-handling controller, per-set tree pseudo-LRU, and saturating hit/miss counters. It replaces the fixed 4-way datapath plus external controller pairing.

---
 rtl/lc3b_types.sv | 19 +
 rtl/l2_plru_tree.sv | 31 +++
 rtl/l2cache_nway.sv | 179 +++++++++++++++++
 tb/tb_l2cache_nway.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lc3b_types.sv
// Shared LC-3b memory-hierarchy types.
// Line payloads, line addresses, L2 controller states, counter helper.
package lc3b_types;

    typedef logic [127:0] lc3b_8words;
    typedef logic [15:0]  lc3b_word;
    typedef logic [11:0]  lc3b_line_adr;

    typedef enum logic [1:0] {
        L2_IDLE,
        L2_WRITEBACK,
        L2_FILL
    } l2_state_e;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/l2_plru_tree.sv
// Combinational tree pseudo-LRU for one set.
// Ports: plru_in (current node bits), touch_way -> plru_next, victim_way.
module l2_plru_tree #(
    parameter int WAYS = 4
) (
    input  logic [WAYS-2:0]         plru_in,
    input  logic [$clog2(WAYS)-1:0] touch_way,
    output logic [WAYS-2:0]         plru_next,
    output logic [$clog2(WAYS)-1:0] victim_way
);

    localparam int WW = $clog2(WAYS);

    // Heap layout: node n (root = 1) lives at bit n-1, children 2n, 2n+1.
    always_comb begin
        int nt;
        int nv;
        plru_next  = plru_in;
        victim_way = '0;
        nt = 1;
        nv = 1;
        for (int l = 0; l < WW; l++) begin
            // Point away from the touched half.
            plru_next[nt-1] = ~touch_way[WW-1-l];
            nt = 2 * nt + int'(touch_way[WW-1-l]);
            victim_way[WW-1-l] = plru_in[nv-1];
            nv = 2 * nv + int'(plru_in[nv-1]);
        end
    end

endmodule

// File: rtl/l2cache_nway.sv
// N-way set-associative write-back/write-allocate L2 with miss FSM.
// Ports: cpu side (adr/read/write/sel/data/resp), mem side, hit/miss counters.
module l2cache_nway
    import lc3b_types::*;
#(
    parameter int WAYS = 4,
    parameter int SETS = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] adr_i_cpu,
    input  logic        cpu_read,
    input  logic        cpu_write,
    input  logic [15:0] cpu_sel,
    input  lc3b_8words  dat_i_cpu,
    output lc3b_8words  dat_o_cpu,
    output logic        cpu_resp,
    output logic [15:0] adr_o_mem,
    output logic        mem_read,
    output logic        mem_write,
    output lc3b_8words  dat_o_mem,
    input  lc3b_8words  dat_i_mem,
    input  logic        mem_resp,
    output logic [15:0] hit_count,
    output logic [15:0] miss_count
);

    localparam int WW = $clog2(WAYS);
    localparam int IW = $clog2(SETS);
    localparam int TW = 12 - IW;

    lc3b_8words      data_q  [WAYS][SETS];
    logic [TW-1:0]   tag_q   [WAYS][SETS];
    logic [SETS-1:0] valid_q [WAYS];
    logic [SETS-1:0] dirty_q [WAYS];
    logic [WAYS-2:0] plru_q  [SETS];

    l2_state_e   state_q, state_d;
    logic [WW-1:0] vict_q;
    logic        refill_q;
    logic [15:0] hit_q, miss_q;

    logic [IW-1:0] idx;
    logic [TW-1:0] tag;
    logic          req;
    logic          hit, inv;
    logic [WW-1:0] hit_way, inv_way, plru_vict, victim_new;
    logic [WAYS-2:0] plru_nxt;
    lc3b_8words    hit_line, merged;
    logic          do_hit, do_miss, do_fill;

    assign idx = adr_i_cpu[4 +: IW];
    assign tag = adr_i_cpu[15 -: TW];
    assign req = cpu_read | cpu_write;

    assign hit_count  = hit_q;
    assign miss_count = miss_q;

    // Descending scan so the lowest matching / invalid way wins.
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        inv     = 1'b0;
        inv_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_q[w][idx] && tag_q[w][idx] == tag) begin
                hit     = 1'b1;
                hit_way = WW'(w);
            end
            if (!valid_q[w][idx]) begin
                inv     = 1'b1;
                inv_way = WW'(w);
            end
        end
    end

    l2_plru_tree #(.WAYS(WAYS)) u_plru (
        .plru_in   (plru_q[idx]),
        .touch_way (hit_way),
        .plru_next (plru_nxt),
        .victim_way(plru_vict)
    );

    assign victim_new = inv ? inv_way : plru_vict;
    assign hit_line   = data_q[hit_way][idx];

    always_comb begin
        merged = hit_line;
        for (int b = 0; b < 16; b++) begin
            if (cpu_sel[b]) merged[8*b +: 8] = dat_i_cpu[8*b +: 8];
        end
    end

    always_comb begin
        state_d   = state_q;
        cpu_resp  = 1'b0;
        dat_o_cpu = '0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        adr_o_mem = '0;
        dat_o_mem = '0;
        do_hit    = 1'b0;
        do_miss   = 1'b0;
        do_fill   = 1'b0;
        unique case (state_q)
            L2_IDLE: begin
                if (req && hit) begin
                    cpu_resp  = 1'b1;
                    dat_o_cpu = hit_line;
                    do_hit    = 1'b1;
                end else if (req) begin
                    do_miss = 1'b1;
                    if (valid_q[victim_new][idx] && dirty_q[victim_new][idx])
                        state_d = L2_WRITEBACK;
                    else
                        state_d = L2_FILL;
                end
            end
            L2_WRITEBACK: begin
                mem_write = 1'b1;
                adr_o_mem = {tag_q[vict_q][idx], idx, 4'h0};
                dat_o_mem = data_q[vict_q][idx];
                if (mem_resp) state_d = L2_FILL;
            end
            L2_FILL: begin
                mem_read  = 1'b1;
                adr_o_mem = {adr_i_cpu[15:4], 4'h0};
                if (mem_resp) begin
                    do_fill = 1'b1;
                    state_d = L2_IDLE;
                end
            end
            default: state_d = L2_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= L2_IDLE;
            vict_q   <= '0;
            refill_q <= 1'b0;
            hit_q    <= '0;
            miss_q   <= '0;
            for (int w = 0; w < WAYS; w++) begin
                valid_q[w] <= '0;
                dirty_q[w] <= '0;
            end
            for (int s = 0; s < SETS; s++) plru_q[s] <= '0;
        end else begin
            state_q <= state_d;
            if (do_miss) begin
                vict_q <= victim_new;
                miss_q <= sat_inc(miss_q);
            end
            if (do_hit) begin
                plru_q[idx] <= plru_nxt;
                refill_q    <= 1'b0;
                // The re-lookup after a fill is not a new hit.
                if (!refill_q) hit_q <= sat_inc(hit_q);
                if (cpu_write) dirty_q[hit_way][idx] <= 1'b1;
            end
            if (do_fill) begin
                refill_q              <= 1'b1;
                valid_q[vict_q][idx]  <= 1'b1;
                dirty_q[vict_q][idx]  <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_fill) begin
            data_q[vict_q][idx] <= dat_i_mem;
            tag_q[vict_q][idx]  <= tag;
        end else if (do_hit && cpu_write) begin
            data_q[hit_way][idx] <= merged;
        end
    end

endmodule

// File: tb/tb_l2cache_nway.sv
// Randomized self-checking bench for l2cache_nway (WAYS=4, SETS=16).
// Behavioural cache + memory model; per-cycle output comparison.
module tb_l2cache_nway;

    localparam int W  = 4;
    localparam int S  = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic [15:0]  adr_i_cpu;
    logic         cpu_read, cpu_write;
    logic [15:0]  cpu_sel;
    logic [127:0] dat_i_cpu, dat_o_cpu;
    logic         cpu_resp;
    logic [15:0]  adr_o_mem;
    logic         mem_read, mem_write;
    logic [127:0] dat_o_mem, dat_i_mem;
    logic         mem_resp;
    logic [15:0]  hit_count, miss_count;

    always #5 clk = ~clk;

    l2cache_nway #(.WAYS(W), .SETS(S)) dut (
        .clk(clk), .reset(reset),
        .adr_i_cpu(adr_i_cpu), .cpu_read(cpu_read), .cpu_write(cpu_write),
        .cpu_sel(cpu_sel), .dat_i_cpu(dat_i_cpu), .dat_o_cpu(dat_o_cpu),
        .cpu_resp(cpu_resp), .adr_o_mem(adr_o_mem), .mem_read(mem_read),
        .mem_write(mem_write), .dat_o_mem(dat_o_mem), .dat_i_mem(dat_i_mem),
        .mem_resp(mem_resp), .hit_count(hit_count), .miss_count(miss_count)
    );

    // Reference state
    logic [127:0] m_data  [W][S];
    logic [7:0]   m_tag   [W][S];
    bit           m_valid [W][S];
    bit           m_dirty [W][S];
    bit [2:0]     m_plru  [S];
    logic [15:0]  m_hits, m_misses;
    logic [127:0] mem [logic [11:0]];

    // Expected outputs for the current cycle
    logic         e_resp, e_mrd, e_mwr;
    logic [127:0] e_cdat, e_mdat;
    logic [15:0]  e_madr;
    bit           chk_en;

    logic [127:0] last_cdat, last_wb_dat;
    logic [15:0]  last_wb_adr, last_fill_adr;

    int n_chk = 0;
    int n_fail = 0;

    function automatic void check(string nm, logic [127:0] act, logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    always @(negedge clk) begin
        if (chk_en && !reset) begin
            check("cpu_resp", 128'(cpu_resp), 128'(e_resp));
            check("dat_o_cpu", dat_o_cpu, e_cdat);
            check("mem_read", 128'(mem_read), 128'(e_mrd));
            check("mem_write", 128'(mem_write), 128'(e_mwr));
            check("adr_o_mem", 128'(adr_o_mem), 128'(e_madr));
            check("dat_o_mem", dat_o_mem, e_mdat);
            check("hit_count", 128'(hit_count), 128'(m_hits));
            check("miss_count", 128'(miss_count), 128'(m_misses));
            if (cpu_resp) last_cdat = dat_o_cpu;
            if (mem_write) begin
                last_wb_adr = adr_o_mem;
                last_wb_dat = dat_o_mem;
            end
            if (mem_read) last_fill_adr = adr_o_mem;
        end
    end

    function automatic logic [15:0] inc16(logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic void model_clear();
        for (int w = 0; w < W; w++)
            for (int s = 0; s < S; s++) begin
                m_valid[w][s] = 0;
                m_dirty[w][s] = 0;
            end
        for (int s = 0; s < S; s++) m_plru[s] = '0;
        m_hits = 0;
        m_misses = 0;
    endfunction

    function automatic int m_lookup(logic [15:0] a);
        int s = int'(a[7:4]);
        for (int w = 0; w < W; w++)
            if (m_valid[w][s] && m_tag[w][s] == a[15:8]) return w;
        return -1;
    endfunction

    // Bit0 = root (1: victim in upper half); bit1 / bit2 = lower / upper pair.
    function automatic int m_victim(int s);
        int half;
        for (int w = 0; w < W; w++)
            if (!m_valid[w][s]) return w;
        half = int'(m_plru[s][0]);
        return half * 2 + int'(m_plru[s][1 + half]);
    endfunction

    function automatic void m_touch(int s, int w);
        m_plru[s][0] = (w < 2);
        m_plru[s][1 + w / 2] = (w % 2 == 0);
    endfunction

    function automatic logic [127:0] mem_line(logic [11:0] la);
        if (mem.exists(la)) return mem[la];
        return {la, 20'hC0FFE, ~la, 20'h5A5A5, la ^ 12'hF0F, 20'h13579,
                la + 12'd7, 20'h2468A};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic zero_exp();
        e_resp = 0; e_cdat = '0; e_mrd = 0; e_mwr = 0;
        e_madr = '0; e_mdat = '0;
    endtask

    task automatic wait_resp(logic [127:0] line);
        repeat ($urandom_range(0, 3)) cyc();
        mem_resp = 1'b1;
        dat_i_mem = line;
        cyc();
        mem_resp = 1'b0;
        dat_i_mem = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic access(bit wr, logic [15:0] a, logic [15:0] sel,
                          logic [127:0] d);
        int s, hw, v;
        bit refill;
        logic [15:0] wa;
        logic [127:0] line;
        s = int'(a[7:4]);
        refill = 0;
        cpu_read = !wr;
        cpu_write = wr;
        adr_i_cpu = a;
        cpu_sel = sel;
        dat_i_cpu = d;
        zero_exp();
        hw = m_lookup(a);
        if (hw < 0) begin
            v = m_victim(s);
            mem_resp = ($urandom_range(0, 3) == 0);
            cyc();
            mem_resp = 1'b0;
            m_misses = inc16(m_misses);
            if (m_valid[v][s] && m_dirty[v][s]) begin
                wa = {m_tag[v][s], a[7:4], 4'h0};
                e_mwr = 1; e_madr = wa; e_mdat = m_data[v][s];
                wait_resp({$urandom, $urandom, $urandom, $urandom});
                mem[wa[15:4]] = m_data[v][s];
            end
            zero_exp();
            e_mrd = 1;
            e_madr = {a[15:4], 4'h0};
            line = mem_line(a[15:4]);
            wait_resp(line);
            m_valid[v][s] = 1;
            m_dirty[v][s] = 0;
            m_tag[v][s] = a[15:8];
            m_data[v][s] = line;
            refill = 1;
            zero_exp();
        end
        hw = m_lookup(a);
        e_resp = 1;
        e_cdat = m_data[hw][s];
        mem_resp = ($urandom_range(0, 3) == 0);
        cyc();
        mem_resp = 1'b0;
        m_touch(s, hw);
        if (!refill) m_hits = inc16(m_hits);
        if (wr) begin
            for (int b = 0; b < 16; b++)
                if (sel[b]) m_data[hw][s][8*b +: 8] = d[8*b +: 8];
            m_dirty[hw][s] = 1;
        end
        cpu_read = 0;
        cpu_write = 0;
        zero_exp();
    endtask

    logic [127:0] L, dk [4];

    initial begin
        reset = 1; cpu_read = 0; cpu_write = 0; adr_i_cpu = '0;
        cpu_sel = '0; dat_i_cpu = '0; dat_i_mem = '0; mem_resp = 0;
        chk_en = 0;
        model_clear();
        zero_exp();
        repeat (2) @(posedge clk);
        #1 reset = 0;
        chk_en = 1;
        @(negedge clk);
        check("rst_counts", 128'({hit_count, miss_count}), 128'(0));
        check("rst_mem", 128'({mem_read, mem_write, cpu_resp}), 128'(0));
        cyc();

        // Read miss then refill-hit
        L = 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF;
        mem[12'h123] = L;
        access(0, 16'h1230, 16'h0, '0);
        check("t1_fill_adr", 128'(last_fill_adr), 128'(16'h1230));
        check("t1_data", last_cdat, 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF);
        check("t1_miss", 128'(miss_count), 128'(1));
        check("t1_hit", 128'(hit_count), 128'(0));

        // Byte-merged write hit
        access(1, 16'h1230, 16'h0003, 128'h0000_BEEF);
        check("t2_hit_w", 128'(hit_count), 128'(1));
        access(0, 16'h1230, 16'h0, '0);
        check("t2_merge", last_cdat, 128'h0011_2233_4455_6677_8899_AABB_CCDD_BEEF);
        check("t2_hit_r", 128'(hit_count), 128'(2));

        // PLRU order 0,1,2,3,0 in set 5 -> dirty victim is way 2
        for (int k = 0; k < 4; k++) begin
            dk[k] = {4{$urandom}};
            access(1, 16'(k * 16'h100 + 16'h0050), 16'hFFFF, dk[k]);
        end
        access(0, 16'h0050, 16'h0, '0);
        access(1, 16'h0450, 16'h00F0, {4{$urandom}});
        check("t3_wb_adr", 128'(last_wb_adr), 128'(16'h0250));
        check("t3_wb_dat", last_wb_dat, dk[2]);
        check("t3_fill_adr", 128'(last_fill_adr), 128'(16'h0450));

        // Reset in the middle of a fill
        cpu_read = 1;
        adr_i_cpu = 16'h5670;
        zero_exp();
        cyc();
        m_misses = inc16(m_misses);
        e_mrd = 1;
        e_madr = 16'h5670;
        cyc();
        #1 chk_en = 0;
        reset = 1;
        #1;
        check("t4_mrd", 128'(mem_read), 128'(0));
        check("t4_counts", 128'({hit_count, miss_count}), 128'(0));
        cpu_read = 0;
        model_clear();
        zero_exp();
        cyc();
        reset = 0;
        chk_en = 1;
        access(0, 16'h5670, 16'h0, '0);
        check("t4_remiss", 128'(miss_count), 128'(1));

        // Random traffic on a small address pool
        for (int i = 0; i < 300; i++) begin
            logic [15:0] a;
            a = {8'($urandom_range(0, 5)), 4'($urandom_range(0, 3)),
                 4'($urandom)};
            access($urandom_range(0, 1) == 1, a, 16'($urandom),
                   {$urandom, $urandom, $urandom, $urandom});
        end

        // Miss counter saturation
        #1 force dut.miss_q = 16'hFFFD;
        #1 release dut.miss_q;
        m_misses = 16'hFFFD;
        for (int k = 0; k < 3; k++)
            access(0, 16'(16'hE090 + k * 16'h100), 16'h0, '0);
        check("t6_sat", 128'(miss_count), 128'(16'hFFFF));

        repeat (2) cyc();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
